// File: rtl/sync_to_count_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_to_count_pkg
// Brief    : Shared VGA timing constants and sync-lock state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package sync_to_count_pkg;

  localparam int C_TOTAL_COLS  = 800;
  localparam int C_TOTAL_ROWS  = 525;
  localparam int C_ACTIVE_COLS = 640;
  localparam int C_ACTIVE_ROWS = 480;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Brief    : Registers a level and flags its rising edge (combinational pulse).
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Sig,
  output logic o_Sig_Q,
  output logic o_Rise
);

  logic r_sig;
  logic r_primed;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_sig    <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_sig    <= i_Sig;
      r_primed <= 1'b1;
    end
  end

  // A level already high when reset releases has no known low phase, so it is not an edge.
  assign o_Sig_Q = r_sig;
  assign o_Rise  = r_primed & i_Sig & ~r_sig;

endmodule
`default_nettype wire

// File: rtl/sync_to_count.sv
`default_nettype none
// ============================================================================
// Module   : sync_to_count
// Brief    : Rebuilds column/row counters from HSync/VSync and tracks frame lock.
// Revision : 1.0 - initial release
// ============================================================================
module sync_to_count
  import sync_to_count_pkg::*;
#(
  parameter int TOTAL_COLS  = C_TOTAL_COLS,
  parameter int TOTAL_ROWS  = C_TOTAL_ROWS,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                          i_Clk,
  input  logic                          i_Rst_L,
  input  logic                          i_HSync,
  input  logic                          i_VSync,
  output logic                          o_HSync,
  output logic                          o_VSync,
  output logic [$clog2(TOTAL_COLS)-1:0] o_Col_Count,
  output logic [$clog2(TOTAL_ROWS)-1:0] o_Row_Count,
  output logic                          o_Frame_Start,
  output logic                          o_Locked,
  output logic                          o_Frame_Err
);

  localparam int COL_W  = $clog2(TOTAL_COLS);
  localparam int ROW_W  = $clog2(TOTAL_ROWS);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);

  localparam logic [COL_W-1:0]  C_COL_LAST = COL_W'(TOTAL_COLS - 1);
  localparam logic [ROW_W-1:0]  C_ROW_LAST = ROW_W'(TOTAL_ROWS - 1);
  localparam logic [GOOD_W-1:0] C_GOOD_MAX = GOOD_W'(LOCK_FRAMES);

  sync_state_t       r_state,       w_state_next;
  logic [COL_W-1:0]  r_col,         w_col_next,  w_col_adv;
  logic [ROW_W-1:0]  r_row,         w_row_next,  w_row_adv;
  logic [GOOD_W-1:0] r_good,        w_good_next, w_good_inc;
  logic              r_frame_start, w_frame_start_next;
  logic              r_frame_err,   w_frame_err_next;
  logic              r_hsync;
  logic              w_vsync_q;
  logic              w_vsync_rise;
  logic              w_col_last;
  logic              w_row_last;
  logic              w_frame_end;

  sync_edge_detect u_vsync_edge (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Sig   (i_VSync),
    .o_Sig_Q (w_vsync_q),
    .o_Rise  (w_vsync_rise)
  );

  always_comb begin
    w_col_last  = (r_col == C_COL_LAST);
    w_row_last  = (r_row == C_ROW_LAST);
    w_frame_end = w_col_last & w_row_last;
    w_col_adv   = w_col_last ? '0 : r_col + COL_W'(1);
    w_row_adv   = r_row;
    if (w_col_last) begin
      w_row_adv = w_row_last ? '0 : r_row + ROW_W'(1);
    end
    w_good_inc  = (r_good == C_GOOD_MAX) ? r_good : r_good + GOOD_W'(1);
  end

  always_comb begin
    w_state_next       = r_state;
    w_col_next         = r_col;
    w_row_next         = r_row;
    w_good_next        = r_good;
    w_frame_start_next = 1'b0;
    w_frame_err_next   = 1'b0;

    case (r_state)
      SEARCH: begin
        w_col_next = '0;
        w_row_next = '0;
        if (w_vsync_rise) begin
          w_frame_start_next = 1'b1;
          w_good_next        = '0;
          w_state_next       = ALIGN;
        end
      end

      ALIGN, LOCKED: begin
        w_col_next = w_col_adv;
        w_row_next = w_row_adv;
        // An edge coinciding with the natural wrap is exactly a nominal-length frame.
        if (w_vsync_rise) begin
          w_col_next         = '0;
          w_row_next         = '0;
          w_frame_start_next = 1'b1;
          if (w_frame_end) begin
            if (r_state == ALIGN) begin
              w_good_next = w_good_inc;
              if (w_good_inc == C_GOOD_MAX) begin
                w_state_next = LOCKED;
              end
            end
          end else begin
            w_good_next      = '0;
            w_frame_err_next = 1'b1;
            w_state_next     = ALIGN;
          end
        end else if ((r_state == LOCKED) && w_frame_end) begin
          w_good_next      = '0;
          w_frame_err_next = 1'b1;
          w_state_next     = ALIGN;
        end
      end

      default: begin
        w_state_next = SEARCH;
        w_col_next   = '0;
        w_row_next   = '0;
        w_good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_state       <= SEARCH;
      r_col         <= '0;
      r_row         <= '0;
      r_good        <= '0;
      r_frame_start <= 1'b0;
      r_frame_err   <= 1'b0;
      r_hsync       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_col         <= w_col_next;
      r_row         <= w_row_next;
      r_good        <= w_good_next;
      r_frame_start <= w_frame_start_next;
      r_frame_err   <= w_frame_err_next;
      r_hsync       <= i_HSync;
    end
  end

  assign o_HSync       = r_hsync;
  assign o_VSync       = w_vsync_q;
  assign o_Col_Count   = r_col;
  assign o_Row_Count   = r_row;
  assign o_Frame_Start = r_frame_start;
  assign o_Frame_Err   = r_frame_err;
  assign o_Locked      = (r_state == LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_sync_to_count.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_to_count
// Brief    : Directed frame-level vectors on a reduced 8x5 timing for sync_to_count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_to_count;

  localparam int COLS  = 8;
  localparam int ROWS  = 5;
  localparam int LOCKF = 2;
  localparam int ACT_C = 6;
  localparam int ACT_R = 4;
  localparam int NVEC  = 11;

  typedef struct {
    string name;
    int    len;
    bit    has_edge;
    bit    e_fs;
    bit    e_err;
    bit    e_lock;
  } frame_vec_t;

  logic       clk   = 1'b0;
  logic       rst_l = 1'b0;
  logic       hs    = 1'b0;
  logic       vs    = 1'b0;
  logic       o_hs, o_vs, o_fs, o_lock, o_err;
  logic [2:0] o_col;
  logic [2:0] o_row;

  int n_checks = 0;
  int n_pass   = 0;

  frame_vec_t vecs [NVEC];

  sync_to_count #(
    .TOTAL_COLS  (COLS),
    .TOTAL_ROWS  (ROWS),
    .LOCK_FRAMES (LOCKF)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_l),
    .i_HSync       (hs),
    .i_VSync       (vs),
    .o_HSync       (o_hs),
    .o_VSync       (o_vs),
    .o_Col_Count   (o_col),
    .o_Row_Count   (o_row),
    .o_Frame_Start (o_fs),
    .o_Locked      (o_lock),
    .o_Frame_Err   (o_err)
  );

  always #5 clk = ~clk;

  // Packed as {hsync, vsync, col[2:0], row[2:0], frame_start, frame_err, locked}.
  task automatic check(input string name, input int k, input logic [10:0] exp);
    logic [10:0] act;
    act = {o_hs, o_vs, o_col, o_row, o_fs, o_err, o_lock};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s k=%0d got {hs,vs,col,row,fs,err,lock}=%b expected %b",
                  name, k, act, exp);
  endtask

  task automatic step(input logic h, input logic v);
    hs = h;
    vs = v;
    @(posedge clk);
    #1;
  endtask

  // Frame position k maps to generator column k%COLS, row k/COLS.
  task automatic run_frame(input string name, input int len, input bit has_edge,
                           input bit e_fs, input bit e_err, input bit e_lock);
    int   c, r;
    logic h, v;
    for (int k = 0; k < len; k++) begin
      c = k % COLS;
      r = k / COLS;
      h = (c < ACT_C);
      v = has_edge && (r < ACT_R);
      step(h, v);
      check(name, k, {h, v, 3'(c), 3'(r), (k == 0) && e_fs, (k == 0) && e_err, e_lock});
    end
  endtask

  initial begin
    int   c, r;
    logic h, v;

    vecs[0]  = '{"lock_edge1",   40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{"lock_edge2",   40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"lock_edge3",   40, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{"short_frame",  33, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{"after_short",  40, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{"relock_a",     40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"relock_b",     40, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"missing_vs",   40, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"post_miss_a",  40, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"post_miss_b",  40, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{"steady_lock",  40, 1'b1, 1'b1, 1'b0, 1'b1};

    rst_l = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0);
      check("reset", i, 11'b0);
    end
    rst_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0);
      check("idle_search", i, 11'b0);
    end

    for (int i = 0; i < NVEC; i++) begin
      run_frame(vecs[i].name, vecs[i].len, vecs[i].has_edge,
                vecs[i].e_fs, vecs[i].e_err, vecs[i].e_lock);
    end

    // Locked frame interrupted by a one-cycle reset at row 2 while VSync is high.
    run_frame("pre_reset", 19, 1'b1, 1'b1, 1'b0, 1'b1);
    rst_l = 1'b0;
    step(1'b1, 1'b1);
    check("reset_mid", 19, 11'b0);
    rst_l = 1'b1;
    for (int k = 20; k < COLS * ROWS; k++) begin
      c = k % COLS;
      r = k / COLS;
      h = (c < ACT_C);
      v = (r < ACT_R);
      step(h, v);
      check("post_reset_hold", k, {h, v, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    end
    run_frame("realign_1", 40, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("realign_2", 40, 1'b1, 1'b1, 1'b0, 1'b0);
    run_frame("realign_3", 40, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
